// File: rtl/phy_link_supervisor_5g.sv
// Link supervisor for the 5GBASE-R transceivers: requests controller resets, retries bring-up
// on timeout or sustained link loss, and publishes aggregate and per-lane link status.
module phy_link_supervisor_5g #(
  parameter int LANES       = 4,
  parameter int RST_CYCLES  = 16,
  parameter int TIMEOUT     = 100000,
  parameter int LOSS_CYCLES = 8,
  parameter int CNT_W       = 20
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             force_reset,
  input  logic [LANES-1:0] tx_ready,
  input  logic [LANES-1:0] rx_ready,
  input  logic [LANES-1:0] rx_is_lockedtodata,
  input  logic [LANES-1:0] rx_block_lock,
  output logic             phy_reset,
  output logic             link_up,
  output logic [LANES-1:0] lane_up,
  output logic [1:0]       state,
  output logic [7:0]       retry_cnt
);

  localparam int                LOSS_W       = $clog2(LOSS_CYCLES + 1);
  localparam logic [CNT_W-1:0]  RST_LOAD     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TIMEOUT_LOAD = CNT_W'(TIMEOUT - 1);
  localparam logic [LOSS_W-1:0] LOSS_LAST    = LOSS_W'(LOSS_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RST     = 2'd0,
    ST_WAIT_TX = 2'd1,
    ST_WAIT_RX = 2'd2,
    ST_UP      = 2'd3
  } state_t;

  state_t            state_reg;
  logic [CNT_W-1:0]  timer_reg;
  logic [LOSS_W-1:0] loss_reg;
  logic [7:0]        retry_cnt_reg;
  logic              phy_reset_reg;
  logic              link_up_reg;
  logic [LANES-1:0]  lane_up_reg;
  logic [LANES-1:0]  block_lock_meta_reg;
  logic [LANES-1:0]  block_lock_sync_reg;
  logic [LANES-1:0]  lane_good;
  logic              all_tx;
  logic              all_good;
  logic              timer_zero;
  logic              to_rst_next;
  logic              retry_next;

  // Block lock comes from the PCS without a clock relationship; two flops per lane.
  always_ff @(posedge clock) begin
    if (reset) begin
      block_lock_meta_reg <= '0;
      block_lock_sync_reg <= '0;
    end else begin
      block_lock_meta_reg <= rx_block_lock;
      block_lock_sync_reg <= block_lock_meta_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign lane_good[gi] = rx_ready[gi] & rx_is_lockedtodata[gi] & block_lock_sync_reg[gi];
    end
  endgenerate

  assign all_tx     = &tx_ready;
  assign all_good   = &lane_good;
  assign timer_zero = (timer_reg == '0);

  // Return-to-RST decision; force_reset wins so a coincident timeout/loss is not counted.
  always_comb begin
    to_rst_next = 1'b0;
    retry_next  = 1'b0;
    if (force_reset) begin
      to_rst_next = 1'b1;
    end else begin
      case (state_reg)
        ST_WAIT_TX: begin
          if (!all_tx && timer_zero) begin
            to_rst_next = 1'b1;
            retry_next  = 1'b1;
          end
        end
        ST_WAIT_RX: begin
          if (!all_good && (!all_tx || timer_zero)) begin
            to_rst_next = 1'b1;
            retry_next  = 1'b1;
          end
        end
        ST_UP: begin
          if (!all_tx || (!all_good && loss_reg == LOSS_LAST)) begin
            to_rst_next = 1'b1;
            retry_next  = 1'b1;
          end
        end
        default: begin
          to_rst_next = 1'b0;
          retry_next  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= ST_RST;
      timer_reg     <= RST_LOAD;
      loss_reg      <= '0;
      retry_cnt_reg <= '0;
      phy_reset_reg <= 1'b1;
      link_up_reg   <= 1'b0;
      lane_up_reg   <= '0;
    end else begin
      if (retry_next && retry_cnt_reg != 8'hFF) begin
        retry_cnt_reg <= retry_cnt_reg + 8'd1;
      end
      if (to_rst_next) begin
        state_reg     <= ST_RST;
        timer_reg     <= RST_LOAD;
        loss_reg      <= '0;
        phy_reset_reg <= 1'b1;
        link_up_reg   <= 1'b0;
        lane_up_reg   <= '0;
      end else begin
        case (state_reg)
          ST_RST: begin
            if (timer_zero) begin
              state_reg     <= ST_WAIT_TX;
              timer_reg     <= TIMEOUT_LOAD;
              phy_reset_reg <= 1'b0;
            end else begin
              timer_reg <= timer_reg - 1'b1;
            end
          end
          ST_WAIT_TX: begin
            if (all_tx) begin
              state_reg <= ST_WAIT_RX;
              timer_reg <= TIMEOUT_LOAD;
            end else if (!timer_zero) begin
              timer_reg <= timer_reg - 1'b1;
            end
          end
          ST_WAIT_RX: begin
            if (all_good) begin
              state_reg   <= ST_UP;
              loss_reg    <= '0;
              link_up_reg <= 1'b1;
              lane_up_reg <= lane_good;
            end else if (!timer_zero) begin
              timer_reg <= timer_reg - 1'b1;
            end
          end
          ST_UP: begin
            // Short glitches are absorbed: lane_up follows live status, link_up holds.
            lane_up_reg <= lane_good;
            loss_reg    <= all_good ? '0 : loss_reg + LOSS_W'(1);
          end
          default: begin
            state_reg <= ST_RST;
            timer_reg <= RST_LOAD;
          end
        endcase
      end
    end
  end

  assign phy_reset = phy_reset_reg;
  assign link_up   = link_up_reg;
  assign lane_up   = lane_up_reg;
  assign state     = state_reg;
  assign retry_cnt = retry_cnt_reg;

endmodule

// File: tb/tb_phy_link_supervisor_5g.sv
// Directed bench for phy_link_supervisor_5g with a cycle model of the link-bringup rules
// and a handful of hand-computed checkpoints.
module tb_phy_link_supervisor_5g;

  localparam int LANES       = 4;
  localparam int RST_CYCLES  = 4;
  localparam int TIMEOUT     = 20;
  localparam int LOSS_CYCLES = 3;
  localparam int CNT_W       = 20;

  logic             clock;
  logic             reset;
  logic             force_reset;
  logic [LANES-1:0] tx_ready;
  logic [LANES-1:0] rx_ready;
  logic [LANES-1:0] rx_is_lockedtodata;
  logic [LANES-1:0] rx_block_lock;
  logic             phy_reset;
  logic             link_up;
  logic [LANES-1:0] lane_up;
  logic [1:0]       state;
  logic [7:0]       retry_cnt;

  phy_link_supervisor_5g #(
    .LANES(LANES), .RST_CYCLES(RST_CYCLES), .TIMEOUT(TIMEOUT),
    .LOSS_CYCLES(LOSS_CYCLES), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .reset(reset), .force_reset(force_reset),
    .tx_ready(tx_ready), .rx_ready(rx_ready),
    .rx_is_lockedtodata(rx_is_lockedtodata), .rx_block_lock(rx_block_lock),
    .phy_reset(phy_reset), .link_up(link_up), .lane_up(lane_up),
    .state(state), .retry_cnt(retry_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec = 0;
  int n_bad = 0;
  bit check_en = 1'b0;

  // Model: phase number, cycles spent in the phase, run of bad cycles, retry tally.
  int               m_phase;
  int               m_elapsed;
  int               m_bad_run;
  int               m_retries;
  logic [LANES-1:0] m_bl_d1, m_bl_d2;
  logic [LANES-1:0] m_good;
  logic [LANES-1:0] m_lane_up;
  int               m_target;
  bit               m_restart, m_count;

  always @(posedge clock) begin
    m_good = rx_ready & rx_is_lockedtodata & m_bl_d2;
    if (reset) begin
      m_phase = 0; m_elapsed = 0; m_bad_run = 0; m_retries = 0;
      m_bl_d1 = '0; m_bl_d2 = '0;
    end else begin
      m_target = m_phase; m_restart = 0; m_count = 0;
      if (force_reset) m_restart = 1;
      else if (m_phase == 0) begin
        if (m_elapsed == RST_CYCLES - 1) m_target = 1;
      end else if (m_phase == 1) begin
        if (&tx_ready) m_target = 2;
        else if (m_elapsed == TIMEOUT - 1) begin m_restart = 1; m_count = 1; end
      end else if (m_phase == 2) begin
        if (&m_good) m_target = 3;
        else if (!(&tx_ready) || m_elapsed == TIMEOUT - 1) begin m_restart = 1; m_count = 1; end
      end else begin
        if (!(&tx_ready)) begin m_restart = 1; m_count = 1; end
        else if (&m_good) m_bad_run = 0;
        else if (m_bad_run + 1 >= LOSS_CYCLES) begin m_restart = 1; m_count = 1; end
        else m_bad_run = m_bad_run + 1;
      end
      if (m_restart) begin m_phase = 0; m_elapsed = 0; m_bad_run = 0; end
      else if (m_target != m_phase) begin m_phase = m_target; m_elapsed = 0; m_bad_run = 0; end
      else m_elapsed = m_elapsed + 1;
      if (m_count && m_retries < 255) m_retries = m_retries + 1;
      m_bl_d2 = m_bl_d1;
      m_bl_d1 = rx_block_lock;
    end
    m_lane_up = (m_phase == 3) ? m_good : '0;
  end

  always @(negedge clock) begin
    if (check_en) begin
      n_vec++;
      if (state !== 2'(m_phase) || phy_reset !== (m_phase == 0) || link_up !== (m_phase == 3) ||
          lane_up !== m_lane_up || retry_cnt !== 8'(m_retries)) begin
        n_bad++;
        $display("FAIL cycle_check t=%0t: got state=%0d phy_reset=%b link_up=%b lane_up=%h retry_cnt=%0d, required state=%0d phy_reset=%b link_up=%b lane_up=%h retry_cnt=%0d",
                 $time, state, phy_reset, link_up, lane_up, retry_cnt,
                 m_phase, (m_phase == 0), (m_phase == 3), m_lane_up, m_retries);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
    else $display("ok   %s = %0h", name, act);
  endtask

  task automatic tx_drop_retry();
    tx_ready = 4'b1110;
    tick();
    tx_ready = 4'hF;
    repeat (8) tick();
  endtask

  int ph_cnt;

  initial begin
    reset = 1'b1; force_reset = 1'b0;
    tx_ready = 4'hF; rx_ready = 4'hF; rx_is_lockedtodata = 4'hF; rx_block_lock = 4'hF;
    tick();
    check_en = 1'b1;
    tick(); tick();
    check_lit("reset_state", 32'(state), 0);
    check_lit("reset_phy_reset", 32'(phy_reset), 1);
    check_lit("reset_link_up", 32'(link_up), 0);
    check_lit("reset_lane_up", 32'(lane_up), 0);
    check_lit("reset_retry", 32'(retry_cnt), 0);

    // Clean bring-up: 4 RST cycles, 1 WAIT_TX, 1 WAIT_RX, then UP.
    reset = 1'b0;
    ph_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      if (phy_reset) ph_cnt++;
      if (k == 4) check_lit("bringup_wait_tx", 32'(state), 1);
      if (k == 5) check_lit("bringup_wait_rx", 32'(state), 2);
      if (k == 6) begin
        check_lit("bringup_up", 32'(state), 3);
        check_lit("bringup_link_up", 32'(link_up), 1);
        check_lit("bringup_lane_up", 32'(lane_up), 32'hF);
        check_lit("bringup_retry", 32'(retry_cnt), 0);
      end
      tick();
    end
    check_lit("bringup_phy_reset_cycles", 32'(ph_cnt), 4);

    // Two-cycle rx_ready glitch is absorbed; three cycles forces a retry.
    rx_ready = 4'b1011;
    tick();
    check_lit("glitch2_lane_dip", 32'(lane_up), 32'hB);
    check_lit("glitch2_link_hold", 32'(link_up), 1);
    tick();
    rx_ready = 4'hF;
    tick(); tick();
    check_lit("glitch2_state", 32'(state), 3);
    check_lit("glitch2_retry", 32'(retry_cnt), 0);
    rx_ready = 4'b1011;
    tick(); tick(); tick();
    check_lit("loss3_state", 32'(state), 0);
    check_lit("loss3_link_up", 32'(link_up), 0);
    check_lit("loss3_retry", 32'(retry_cnt), 1);
    rx_ready = 4'hF;
    repeat (8) tick();
    check_lit("recover1_state", 32'(state), 3);

    // One-cycle tx_ready drop in UP retries immediately.
    tx_ready = 4'b1110;
    tick();
    tx_ready = 4'hF;
    check_lit("txdrop_state", 32'(state), 0);
    check_lit("txdrop_link_up", 32'(link_up), 0);
    check_lit("txdrop_retry", 32'(retry_cnt), 2);
    repeat (8) tick();
    check_lit("recover2_state", 32'(state), 3);

    // Block-lock glitch shows up two cycles later through the synchronizer.
    rx_block_lock = 4'b1101;
    tick();
    rx_block_lock = 4'hF;
    tick(); tick();
    check_lit("blk_sync_latency", 32'(lane_up), 32'hD);
    tick();
    check_lit("blk_recovered", 32'(lane_up), 32'hF);
    check_lit("blk_no_retry", 32'(retry_cnt), 2);

    // force_reset coinciding with the third loss cycle: no retry counted.
    rx_ready = 4'b1011;
    tick(); tick();
    force_reset = 1'b1;
    tick();
    force_reset = 1'b0;
    rx_ready = 4'hF;
    check_lit("force_loss_state", 32'(state), 0);
    check_lit("force_loss_retry", 32'(retry_cnt), 2);
    tick(); tick();
    force_reset = 1'b1;
    tick();
    force_reset = 1'b0;
    ph_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      if (phy_reset) ph_cnt++;
      tick();
    end
    check_lit("force_rst_hold", 32'(ph_cnt), 4);
    check_lit("force_rst_release", 32'(state), 1);
    repeat (4) tick();
    check_lit("recover3_state", 32'(state), 3);

    // Build retry_cnt to 5, park in WAIT_RX, then assert reset.
    tx_drop_retry();
    tx_drop_retry();
    tx_ready = 4'b1110;
    tick();
    tx_ready = 4'hF;
    rx_is_lockedtodata = 4'b1110;
    check_lit("retry_five", 32'(retry_cnt), 5);
    repeat (5) tick();
    check_lit("park_wait_rx", 32'(state), 2);
    reset = 1'b1;
    tick();
    check_lit("midreset_state", 32'(state), 0);
    check_lit("midreset_retry", 32'(retry_cnt), 0);
    check_lit("midreset_phy_reset", 32'(phy_reset), 1);
    check_lit("midreset_lane_up", 32'(lane_up), 0);
    reset = 1'b0;
    rx_is_lockedtodata = 4'hF;

    // WAIT_TX timeout with one lane never ready, repeated until saturation.
    tx_ready = 4'b0111;
    for (int k = 0; k < 25; k++) begin
      if (k == 4)  check_lit("tmo_enter_wait_tx", 32'(state), 1);
      if (k == 23) check_lit("tmo_last_wait_tx", 32'(state), 1);
      if (k == 24) begin
        check_lit("tmo_back_to_rst", 32'(state), 0);
        check_lit("tmo_retry", 32'(retry_cnt), 1);
      end
      tick();
    end
    repeat (24 * 256) tick();
    check_lit("retry_saturated", 32'(retry_cnt), 255);
    repeat (50) tick();
    check_lit("retry_holds", 32'(retry_cnt), 255);

    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/phy_link_supervisor_5g.md
Name: phy_link_supervisor_5g

Overview:
- Consumer-side counterpart of the 5G transceiver reset controller.
- Watches the controller's per-lane tx_ready/rx_ready, the PHY's rx_is_lockedtodata and the PCS block-lock flags.
- Drives the controller's reset request input, retrying bring-up on timeout or link loss.
- Publishes aggregate and per-lane link status to the MAC/framing logic of the 5GBASE-R path.

Parameters:
- LANES, 4, number of transceiver lanes supervised.
- RST_CYCLES, 16, cycles phy_reset is held high per reset attempt (>=1).
- TIMEOUT, 100000, cycles allowed in each WAIT state before retry (>=1).
- LOSS_CYCLES, 8, consecutive bad cycles on any lane in UP before retry (>=1).
- CNT_W, 20, timer width; must hold max(RST_CYCLES, TIMEOUT).

Ports:
- clock  in  1  single clock, same domain as the reset controller.
- reset  in  1  synchronous, active-high.
- force_reset  in  1  single-cycle request to restart bring-up.
- tx_ready  in  LANES  per-lane TX ready from the reset controller.
- rx_ready  in  LANES  per-lane RX ready from the reset controller.
- rx_is_lockedtodata  in  LANES  CDR lock from the PHY (clock domain).
- rx_block_lock  in  LANES  PCS block lock; asynchronous, 2-flop synchronized internally.
- phy_reset  out  1  reset request to the reset controller.
- link_up  out  1  all lanes up.
- lane_up  out  LANES  per-lane good = rx_ready & rx_is_lockedtodata & synced block_lock, valid only in UP.
- state  out  2  0=RST, 1=WAIT_TX, 2=WAIT_RX, 3=UP.
- retry_cnt  out  8  saturating count of timeout/loss retries.

Behaviour:
- Reset: state=RST, timer=RST_CYCLES-1, phy_reset=1, link_up=0, lane_up=0, retry_cnt=0, loss counter=0, sync flops=0.
- All outputs are registered.
- RST:
  - phy_reset=1. The timer decrements each cycle; at timer==0, go to WAIT_TX.
  - After reset deasserts, phy_reset stays high for exactly RST_CYCLES cycles.
  - phy_reset=0 on the first WAIT_TX cycle.
- WAIT_TX:
  - Timer loaded to TIMEOUT-1 on entry.
  - If &tx_ready, go to WAIT_RX.
  - Else at timer==0, go to RST with retry_cnt+1.
- WAIT_RX:
  - Timer reloaded to TIMEOUT-1 on entry.
  - If &lane_good (lane_good = rx_ready & rx_is_lockedtodata & block_lock_s), go to UP.
  - Else if any tx_ready=0, go to RST with retry.
  - Else at timer==0, go to RST with retry.
- UP:
  - link_up=1 and lane_up=lane_good, registered; both take effect on the first UP cycle.
  - Any tx_ready=0: go to RST with retry in the next cycle (no debounce).
  - Any lane_good=0: the loss counter increments. When it reaches LOSS_CYCLES consecutive bad cycles, go to RST with retry.
  - A cycle with &lane_good clears the loss counter, so glitches shorter than LOSS_CYCLES are absorbed.
  - While glitching, lane_up still reflects live lane_good; link_up stays 1 until the state leaves UP.
- Entering RST from any state:
  - Reload timer to RST_CYCLES-1 and clear the loss counter.
  - Set phy_reset=1, link_up=0, lane_up=0 in the first RST cycle.
- force_reset=1 in any state: go to RST next cycle.
  - Restarts the RST hold if already in RST.
  - Does not increment retry_cnt.
  - Has priority over simultaneous timeout/loss, so no retry is counted in that cycle.
- retry_cnt saturates at 255 and is cleared only by reset.
- The initial bring-up after reset is not a retry.
- Reset asserted mid-operation (any state) returns to the reset values on the next edge.
- Timer never wraps; it is only reloaded on state entry.

Test Plan (RST_CYCLES=4, TIMEOUT=20, LOSS_CYCLES=3, LANES=4):
- Release reset with all inputs 1 and block_lock 1 → phy_reset high exactly 4 cycles, WAIT_TX 1 cycle, WAIT_RX 1 cycle; link_up=1 and lane_up=4'hF within 2+sync latency cycles; retry_cnt=0.
- tx_ready=4'b0111 held → after 20 WAIT_TX cycles, state=RST, phy_reset=1 for 4 cycles, retry_cnt=1; repeats, reaching 255 and holding (no wrap).
- In UP, drop rx_ready[2] for 2 cycles then restore → link_up stays 1, lane_up[2] dips for 2 cycles, no retry; drop for 3 cycles → RST, retry_cnt+1, link_up=0.
- In UP, drop tx_ready[0] for 1 cycle → next cycle state=RST, link_up=0, retry_cnt+1.
- force_reset pulse in UP coinciding with 3rd loss cycle → RST, retry_cnt unchanged; force_reset during RST with timer=1 → phy_reset held 4 more cycles.
- Assert reset in WAIT_RX with retry_cnt=5 → next cycle state=RST, retry_cnt=0, phy_reset=1, lane_up=0.
